// File: rtl/operand_sequencer.sv
// operand_sequencer: plays a loadable table of (a, b, expected) vectors onto a1/b1
// and checks each processor result, counting passes and failures.
module operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 7,
    parameter int CNT_W       = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_a,
    input  logic [WIDTH-1:0] ld_b,
    input  logic [WIDTH-1:0] ld_exp,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    input  logic             loop,
    input  logic             abort,
    input  logic [WIDTH-1:0] dut_result,
    input  logic             dut_done,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b1,
    output logic             op_valid,
    output logic [AW-1:0]    vec_idx,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic             timeout,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [AW:0] DMAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t state, state_nx;
    logic [WIDTH-1:0] tab_a [DEPTH];
    logic [WIDTH-1:0] tab_b [DEPTH];
    logic [WIDTH-1:0] tab_e [DEPTH];
    logic [AW:0] nv, nv_in;
    logic [AW-1:0] idx, nxt;
    logic [TW-1:0] timer;
    logic [WIDTH-1:0] cap;
    logic tflag, idle, run, last, fail, hold_end;

    always_comb begin
        idle     = state == S_IDLE || state == S_DONE;
        run      = state == S_WAIT || state == S_CHECK;
        nv_in    = num_vec > DMAX ? DMAX : num_vec;
        last     = (AW + 1)'(idx) == nv - (AW + 1)'(1);
        nxt      = last ? '0 : idx + AW'(1);
        fail     = tflag || cap != tab_e[idx];
        hold_end = timer == TW'(HOLD_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = !start ? state : nv_in == '0 ? S_DONE : S_WAIT;
            S_WAIT:         state_nx = abort ? S_IDLE : (dut_done || hold_end) ? S_CHECK : S_WAIT;
            S_CHECK:        state_nx = abort ? S_IDLE : (!last || loop) ? S_WAIT : S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = run;
        done    = state == S_DONE;
        vec_idx = idx;
    end

    // A start in the same cycle as a table write reads the old contents: the
    // write and the operand load both resolve on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_a[i] <= '0;
                tab_b[i] <= '0;
                tab_e[i] <= '0;
            end
            nv       <= '0;
            idx      <= '0;
            timer    <= '0;
            tflag    <= 1'b0;
            cap      <= '0;
            a1       <= '0;
            b1       <= '0;
            op_valid <= 1'b0;
            mismatch <= 1'b0;
            timeout  <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            mismatch <= 1'b0;
            timeout  <= 1'b0;
            if (ld_en && idle) begin
                tab_a[ld_addr] <= ld_a;
                tab_b[ld_addr] <= ld_b;
                tab_e[ld_addr] <= ld_exp;
            end
            if (run && abort) begin
                op_valid <= 1'b0;
                a1       <= '0;
                b1       <= '0;
            end else if (idle && start) begin
                nv       <= nv_in;
                pass_cnt <= '0;
                fail_cnt <= '0;
                if (nv_in != '0) begin
                    idx      <= '0;
                    a1       <= tab_a[0];
                    b1       <= tab_b[0];
                    op_valid <= 1'b1;
                    timer    <= '0;
                end
            end else if (state == S_WAIT) begin
                if (dut_done) begin
                    cap      <= dut_result;
                    tflag    <= 1'b0;
                    op_valid <= 1'b0;
                end else if (hold_end) begin
                    tflag    <= 1'b1;
                    op_valid <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end else if (state == S_CHECK) begin
                mismatch <= fail;
                timeout  <= tflag;
                if (fail)
                    fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
                else
                    pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
                if (!last || loop) begin
                    idx      <= nxt;
                    a1       <= tab_a[nxt];
                    b1       <= tab_b[nxt];
                    op_valid <= 1'b1;
                    timer    <= '0;
                end else begin
                    a1 <= '0;
                    b1 <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed test-plan scenarios plus randomized runs, checked
// every cycle against a vector-level behavioural model of the sequencer.
module tb_operand_sequencer;
    localparam int H = 7;

    logic clk, reset, ld_en, start, loop, abort, dut_done;
    logic [3:0] ld_addr;
    logic [7:0] ld_a, ld_b, ld_exp, dut_result;
    logic [4:0] num_vec;
    logic [7:0] a1, b1, pass_cnt, fail_cnt;
    logic [3:0] vec_idx;
    logic op_valid, busy, done, mismatch, timeout;

    operand_sequencer #(.WIDTH(8), .DEPTH(16), .HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
        .ld_exp(ld_exp), .num_vec(num_vec), .start(start), .loop(loop), .abort(abort),
        .dut_result(dut_result), .dut_done(dut_done), .a1(a1), .b1(b1), .op_valid(op_valid),
        .vec_idx(vec_idx), .busy(busy), .done(done), .mismatch(mismatch), .timeout(timeout),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: phase 0 idle, 1 presenting a vector, 2 judging it, 3 finished.
    logic [7:0] ma [16];
    logic [7:0] mb [16];
    logic [7:0] me [16];
    logic [7:0] m_cap, e_a1, e_b1;
    int m_st, m_idx, m_n, m_held, e_pass, e_fail;
    bit m_tf, e_ov, e_mis, e_to;

    function automatic int clampn(int v);
        return v > 16 ? 16 : v;
    endfunction

    function automatic int bump(int v);
        return v >= 255 ? 255 : v + 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] <= 0;
                mb[i] <= 0;
                me[i] <= 0;
            end
            m_st <= 0; m_idx <= 0; m_n <= 0; m_held <= 0; m_tf <= 0; m_cap <= 0;
            e_a1 <= 0; e_b1 <= 0; e_ov <= 0; e_mis <= 0; e_to <= 0; e_pass <= 0; e_fail <= 0;
        end else begin
            e_mis <= 0;
            e_to <= 0;
            if (ld_en && (m_st == 0 || m_st == 3)) begin
                ma[ld_addr] <= ld_a;
                mb[ld_addr] <= ld_b;
                me[ld_addr] <= ld_exp;
            end
            if ((m_st == 0 || m_st == 3) && start) begin
                m_n <= clampn(num_vec);
                e_pass <= 0;
                e_fail <= 0;
                if (clampn(num_vec) == 0) m_st <= 3;
                else begin
                    m_st <= 1; m_idx <= 0; m_held <= 1; e_a1 <= ma[0]; e_b1 <= mb[0]; e_ov <= 1;
                end
            end else if ((m_st == 1 || m_st == 2) && abort) begin
                m_st <= 0; e_ov <= 0; e_a1 <= 0; e_b1 <= 0;
            end else if (m_st == 1) begin
                if (dut_done) begin
                    m_cap <= dut_result; m_tf <= 0; m_st <= 2; e_ov <= 0;
                end else if (m_held == H) begin
                    m_tf <= 1; m_st <= 2; e_ov <= 0;
                end else m_held <= m_held + 1;
            end else if (m_st == 2) begin
                e_mis <= m_tf || m_cap != me[m_idx];
                e_to <= m_tf;
                if (m_tf || m_cap != me[m_idx]) e_fail <= bump(e_fail);
                else e_pass <= bump(e_pass);
                if (m_idx < m_n - 1) begin
                    m_idx <= m_idx + 1; e_a1 <= ma[m_idx + 1]; e_b1 <= mb[m_idx + 1];
                    e_ov <= 1; m_held <= 1; m_st <= 1;
                end else if (loop) begin
                    m_idx <= 0; e_a1 <= ma[0]; e_b1 <= mb[0]; e_ov <= 1; m_held <= 1; m_st <= 1;
                end else begin
                    m_st <= 3; e_a1 <= 0; e_b1 <= 0;
                end
            end
        end
    end

    // Processor stand-in: answers each presented vector after a chosen latency.
    int held, lat, force_lat, bad_idx, to_idx;
    bit rnd_bad, noise;
    initial begin
        dut_done = 0; dut_result = 0; held = 0; lat = 0;
        forever begin
            @(negedge clk);
            held = op_valid ? held + 1 : 0;
            if (held == 1)
                lat = (vec_idx == to_idx) ? 99 : force_lat > 0 ? force_lat : $urandom_range(1, 8);
            if (op_valid && held == lat) begin
                dut_done = 1;
                dut_result = me[vec_idx];
                if (vec_idx == bad_idx) dut_result = 8'd6;
                if (rnd_bad && $urandom_range(0, 3) == 0)
                    dut_result = me[vec_idx] ^ 8'($urandom_range(1, 255));
            end else begin
                dut_done = !op_valid && noise && $urandom_range(0, 7) == 0;
                dut_result = 8'($urandom);
            end
        end
    end

    int n_tests, n_fail, mis_seen, to_seen;
    bit prev_ov;
    int seq[$];

    task automatic check(string nm, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset) begin
            check("a1", a1, e_a1);
            check("b1", b1, e_b1);
            check("op_valid", op_valid, e_ov);
            check("busy", busy, m_st == 1 || m_st == 2);
            check("done", done, m_st == 3);
            check("mismatch", mismatch, e_mis);
            check("timeout", timeout, e_to);
            check("pass_cnt", pass_cnt, e_pass);
            check("fail_cnt", fail_cnt, e_fail);
            if (m_st == 1 || m_st == 2) check("vec_idx", vec_idx, m_idx);
        end
        if (mismatch) mis_seen++;
        if (timeout) to_seen++;
        if (op_valid && !prev_ov) seq.push_back(vec_idx);
        prev_ov = op_valid;
    endtask

    task automatic load(int addr, int a, int b, int e);
        ld_en = 1; ld_addr = 4'(addr); ld_a = 8'(a); ld_b = 8'(b); ld_exp = 8'(e);
        tick();
        ld_en = 0;
    endtask

    task automatic go(int n, bit lp);
        num_vec = 5'(n); loop = lp; start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 500) begin
            tick();
            k++;
        end
        check("run_finishes", busy, 0);
    endtask

    task automatic check_all_zero(string nm);
        check({nm, "_a1"}, a1, 0); check({nm, "_b1"}, b1, 0); check({nm, "_op_valid"}, op_valid, 0);
        check({nm, "_busy"}, busy, 0); check({nm, "_done"}, done, 0); check({nm, "_mismatch"}, mismatch, 0);
        check({nm, "_timeout"}, timeout, 0); check({nm, "_pass"}, pass_cnt, 0); check({nm, "_fail"}, fail_cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, mis0, cnt, k;
        reset = 1; ld_en = 0; ld_addr = 0; ld_a = 0; ld_b = 0; ld_exp = 0; num_vec = 0;
        start = 0; loop = 0; abort = 0; force_lat = 2; bad_idx = -1; to_idx = -1;
        rnd_bad = 0; noise = 0; n_tests = 0; n_fail = 0; mis_seen = 0; to_seen = 0; prev_ov = 0;
        #2 reset = 0;
        #1 check_all_zero("reset");
        tick(); tick();
        reset = 1;
        tick();

        load(0, 3, 5, 8); load(1, 12, 7, 5); load(2, 4, 7, 11); load(3, 11, 3, 14);
        base = seq.size(); mis0 = mis_seen;
        go(4, 0);
        wait_idle();
        check("allpass_pass", pass_cnt, 4);
        check("allpass_fail", fail_cnt, 0);
        check("allpass_done", done, 1);
        check("allpass_mis", mis_seen - mis0, 0);
        check("allpass_nvec", seq.size() - base, 4);
        for (int i = 0; i < 4 && base + i < seq.size(); i++) check("allpass_seq", seq[base + i], i);

        bad_idx = 1; mis0 = mis_seen;
        go(4, 0);
        wait_idle();
        bad_idx = -1;
        check("wrong1_mis", mis_seen - mis0, 1);
        check("wrong1_fail", fail_cnt, 1);
        check("wrong1_pass", pass_cnt, 3);

        to_idx = 0; mis0 = to_seen;
        go(4, 0);
        cnt = 0; k = 0;
        while (op_valid && k < 50) begin
            cnt++;
            tick();
            k++;
        end
        to_idx = -1;
        check("tmo_hold_cycles", cnt, 7);
        tick();
        check("tmo_mismatch", mismatch, 1);
        check("tmo_timeout", timeout, 1);
        check("tmo_next_ov", op_valid, 1);
        check("tmo_next_idx", vec_idx, 1);
        wait_idle();
        check("tmo_fail", fail_cnt, 1);
        check("tmo_pass", pass_cnt, 3);

        go(2, 1);
        k = 0;
        while (pass_cnt != 10 && k < 300) begin
            tick();
            k++;
        end
        check("loop_pass10", pass_cnt, 10);
        check("loop_in_wait", op_valid, 1);
        abort = 1;
        tick();
        abort = 0; loop = 0;
        check("abort_ov", op_valid, 0);
        check("abort_a1", a1, 0);
        check("abort_b1", b1, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_pass", pass_cnt, 10);

        base = seq.size();
        go(0, 0);
        check("nv0_done", done, 1);
        check("nv0_pass", pass_cnt, 0);
        check("nv0_fail", fail_cnt, 0);
        tick();
        check("nv0_no_vec", seq.size() - base, 0);

        force_lat = 4;
        go(1, 0);
        load(0, 99, 98, 97);
        wait_idle();
        go(1, 0);
        check("ldwait_a1", a1, 3);
        check("ldwait_b1", b1, 5);
        wait_idle();
        check("ldwait_pass", pass_cnt, 1);

        go(4, 0);
        tick();
        #3 reset = 0;
        #1 check_all_zero("async_reset");
        tick();
        reset = 1;
        tick();
        go(1, 0);
        check("post_reset_a1", a1, 0);
        check("post_reset_b1", b1, 0);
        wait_idle();
        check("post_reset_pass", pass_cnt, 1);

        force_lat = 0; rnd_bad = 1; noise = 1;
        repeat (40) begin
            repeat ($urandom_range(0, 6))
                load($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            go($urandom_range(0, 20), $urandom_range(0, 3) == 0);
            k = 0;
            while (busy && k < 400) begin
                abort = $urandom_range(0, 60) == 0;
                ld_en = $urandom_range(0, 10) == 0;
                ld_addr = 4'($urandom); ld_a = 8'($urandom); ld_b = 8'($urandom); ld_exp = 8'($urandom);
                start = $urandom_range(0, 15) == 0;
                if (k > 30) loop = 0;
                tick();
                k++;
            end
            abort = 0; ld_en = 0; start = 0; loop = 0;
            check("rand_run_ends", busy, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
